instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch unit sitting directly upstream of the control unit in the 16-bit processor. It owns the program counter, drives the synchronous instruction memory from the control unit's `imem_read`, `pc_inc` and `jump` strobes, and steers each returned word into either the instruction register (`ir`, consumed by the control unit) or the operand register (`operand`, the immediate for LOADIM and the target for JUMPNZ). It also resolves the JUMPNZ branch against the ALU zero flag.

## Interface
- `BUS_WIDTH`, 16, instruction/data word width
- `OPCODE_LEN`, 4, opcode field width at `ir[BUS_WIDTH-1 -: OPCODE_LEN]`
- `PC_WIDTH`, 8, program counter and instruction-memory address width
- `clk`  in  1  single clock, all state updates on the rising edge
- `reset`  in  1  synchronous, active-high reset
- `imem_read`  in  1  control unit: issue one read at the current `pc`
- `pc_inc`  in  1  control unit: advance `pc`
- `jump`  in  1  control unit: qualifies `pc_inc` as a JUMPNZ resolution
- `z_flag`  in  1  ALU zero flag, sampled only with `jump & pc_inc`
- `imem_rdata`  in  BUS_WIDTH  memory read data, valid one cycle after `imem_en`
- `imem_en`  out  1  memory read enable, equal to `imem_read & ~reset`
- `imem_addr`  out  PC_WIDTH  equal to `pc`
- `pc`  out  PC_WIDTH  program counter
- `ir`  out  BUS_WIDTH  instruction register
- `operand`  out  BUS_WIDTH  operand register
- `ir_load`  out  1  one-cycle pulse in the cycle after `ir` is updated
- `halt`  out  1  sticky halt (see Configuration)

## Operation
- Reset values: `pc`=0, `ir`=0, `operand`=0, `ir_load`=0, `halt`=0, read pipeline IDLE, `need_operand`=0. `imem_en` is low while `reset` is high.
- Read pipeline states:
  - IDLE: on `imem_read`, latch destination into `pend_dst` and go to PEND.
  - PEND: at the next edge, write `imem_rdata` to `pend_dst`. If `imem_read` is high again, accept a new request back-to-back and stay in PEND; otherwise return to IDLE.
- Destination rule:
  - A request targets `operand` when `need_operand` is 1; otherwise it targets `ir`.
  - `need_operand` is set when the `ir` capture carries opcode 0x2 (LOADIM) or 0xB (JUMPNZ). It is cleared on the `operand` capture.
  - When a request coincides with an `ir` capture edge, the request uses the post-capture `need_operand` value.
- PC update, in priority order:
  - `reset`: `pc` = 0.
  - `pc_inc & jump & ~z_flag`: `pc` = `operand[PC_WIDTH-1:0]`.
  - `pc_inc`: `pc` = `pc`+1, wrapping modulo 2^PC_WIDTH (0xFF+1 gives 0x00).
  - `jump` without `pc_inc` has no effect.
- When `imem_read` and `pc_inc` are high together, the read uses the pre-increment `pc`.
- When `reset` is asserted while in PEND, the pending capture is discarded.

## Timing
- Cycle N: `imem_read`=1, so `imem_en`=1 and `imem_addr`=`pc`.
- Edge ending N+1: destination register updated.
- Cycle N+2: `ir_load`=1 (`ir` destination only).
- This meets the control unit's fetch sequence: read in FETCH-1, new `ir` visible before the decode state.
- Sustained throughput is one read per cycle.

## Configuration
- Macro: `INSTR_FETCH_HALT_EN`.
- Defined: an `ir` capture with opcode 0xF sets `halt`, which stays high until `reset`. While `halt` is high, `imem_en` is forced low, `pc` is frozen, and further requests are ignored.
- Undefined: `halt` is tied 0 and opcode 0xF is fetched like any other instruction.

## Structure
- Shared package `cpu_pkg` holds:
  - opcode constants (`OP_LOADIM`=4'h2, `OP_JUMPNZ`=4'hB, `OP_END`=4'hF)
  - the read-pipeline state enum (IDLE, PEND)
  - the destination enum (DST_IR, DST_OPERAND)
- One sub-module, `pc_counter`: holds `pc` and implements reset, load, increment and wrap; `instr_fetch` supplies the load enable and the load value.

## Test plan
- Reset, memory word 0 = 0x7123, pulse `imem_read` -> `ir`=0x7123 after 2 edges, `ir_load` pulses once, `operand` stays 0.
- Words 0x2100, 0x00AB with reads at pc 0 and 1 -> `ir`=0x2100, `operand`=0x00AB, `need_operand` returns to 0.
- JUMPNZ 0xB120 with target word 0x0040, `jump`+`pc_inc` with `z_flag`=0 -> `pc`=0x40; repeat with `z_flag`=1 -> `pc`=old+1.
- `pc`=0xFF, `pc_inc` -> `pc`=0x00; `imem_read`+`pc_inc` in the same cycle -> `imem_addr` shows the old value.
- `reset` during PEND -> no register update, `pc`=0, `ir`=0, next read targets `ir`.
- With `INSTR_FETCH_HALT_EN`: fetch 0xF000 -> `halt`=1; further `imem_read` gives `imem_en`=0 and `pc` unchanged; `reset` clears `halt`.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and constants for the fetch unit.
// Opcode values, read-pipeline states and capture destinations.
package cpu_pkg;

  localparam logic [3:0] OP_LOADIM = 4'h2;
  localparam logic [3:0] OP_JUMPNZ = 4'hB;
  localparam logic [3:0] OP_END    = 4'hF;

  typedef enum logic {
    IDLE,
    PEND
  } rd_state_e;

  typedef enum logic {
    DST_IR,
    DST_OPERAND
  } dst_e;

  function automatic logic has_operand(
    input logic [3:0] op
  );
    return (op == OP_LOADIM) ||
           (op == OP_JUMPNZ);
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction-memory bus between fetch unit and memory.
// The master issues the read; data returns one cycle later.
interface instr_fetch_if #(
  parameter int BUS_WIDTH = 16,
  parameter int PC_WIDTH  = 8
) ();

  logic                 imem_en;
  logic [PC_WIDTH-1:0]  imem_addr;
  logic [BUS_WIDTH-1:0] imem_rdata;

  modport master (
    output imem_en,
    output imem_addr,
    input  imem_rdata
  );

  modport slave (
    input  imem_en,
    input  imem_addr,
    output imem_rdata
  );

endinterface

// File: rtl/pc_counter.sv
// Program counter: reset, load, increment with natural wrap.
// Load takes priority over increment.
module pc_counter #(
  parameter int PC_WIDTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load_i,
  input  logic [PC_WIDTH-1:0] load_val_i,
  input  logic                inc_i,
  output logic [PC_WIDTH-1:0] pc_o
);

  logic [PC_WIDTH-1:0] pc_q;
  logic [PC_WIDTH-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load_i)
      pc_d = load_val_i;
    else if (inc_i)
      pc_d = pc_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset)
      pc_q <= '0;
    else
      pc_q <= pc_d;
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/instr_fetch.sv
// Fetch unit: PC, one-deep read pipeline, IR/operand steering.
// Optional sticky halt on opcode 0xF under INSTR_FETCH_HALT_EN.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int BUS_WIDTH  = 16,
  parameter int OPCODE_LEN = 4,
  parameter int PC_WIDTH   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 imem_read,
  input  logic                 pc_inc,
  input  logic                 jump,
  input  logic                 z_flag,
  instr_fetch_if.master        imem,
  output logic [PC_WIDTH-1:0]  pc,
  output logic [BUS_WIDTH-1:0] ir,
  output logic [BUS_WIDTH-1:0] operand,
  output logic                 ir_load,
  output logic                 halt
);

  rd_state_e state_q, state_d;
  dst_e      dst_q, dst_d;

  logic [BUS_WIDTH-1:0] ir_q;
  logic [BUS_WIDTH-1:0] op_q;
  logic                 need_q, need_d;
  logic                 ir_load_q;
  logic                 halted;

  logic                  req;
  logic                  cap_ir;
  logic                  cap_op;
  logic [OPCODE_LEN-1:0] rd_opc;

  assign rd_opc =
    imem.imem_rdata[BUS_WIDTH-1 -: OPCODE_LEN];

  always_ff @(posedge clk) begin
    if (reset)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (req) state_d = PEND;
      PEND: state_d = req ? PEND : IDLE;
    endcase
  end

  always_comb begin
    req    = imem_read & ~halted;
    cap_ir = 1'b0;
    cap_op = 1'b0;
    if (state_q == PEND && !halted) begin
      cap_ir = (dst_q == DST_IR);
      cap_op = (dst_q == DST_OPERAND);
    end
  end

  // A request issued on a capture edge sees the updated flag.
  always_comb begin
    need_d = need_q;
    if (cap_ir)
      need_d = has_operand(rd_opc);
    else if (cap_op)
      need_d = 1'b0;
    dst_d = need_d ? DST_OPERAND : DST_IR;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dst_q     <= DST_IR;
      ir_q      <= '0;
      op_q      <= '0;
      need_q    <= 1'b0;
      ir_load_q <= 1'b0;
    end else begin
      if (req)
        dst_q <= dst_d;
      if (cap_ir)
        ir_q <= imem.imem_rdata;
      if (cap_op)
        op_q <= imem.imem_rdata;
      need_q    <= need_d;
      ir_load_q <= cap_ir;
    end
  end

`ifdef INSTR_FETCH_HALT_EN
  logic halt_q;

  always_ff @(posedge clk) begin
    if (reset)
      halt_q <= 1'b0;
    else if (cap_ir && rd_opc == OP_END)
      halt_q <= 1'b1;
  end

  assign halted = halt_q;
`else
  assign halted = 1'b0;
`endif

  pc_counter #(
    .PC_WIDTH (PC_WIDTH)
  ) u_pc (
    .clk        (clk),
    .reset      (reset),
    .load_i     (pc_inc & jump & ~z_flag & ~halted),
    .load_val_i (op_q[PC_WIDTH-1:0]),
    .inc_i      (pc_inc & ~halted),
    .pc_o       (pc)
  );

  assign imem.imem_en   = imem_read & ~reset & ~halted;
  assign imem.imem_addr = pc;

  assign ir      = ir_q;
  assign operand = op_q;
  assign ir_load = ir_load_q;
  assign halt    = halted;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a synchronous memory model.
// Halt checks follow INSTR_FETCH_HALT_EN.
module tb_instr_fetch;

  logic clk = 1'b0;
  logic reset, imem_read, pc_inc, jump, z_flag;
  logic [7:0]  pc;
  logic [15:0] ir, operand;
  logic        ir_load, halt;
  logic [15:0] mem [256];

  int checks = 0;
  int errors = 0;

  instr_fetch_if #(.BUS_WIDTH(16), .PC_WIDTH(8)) imem ();

  instr_fetch dut (
    .clk       (clk),
    .reset     (reset),
    .imem_read (imem_read),
    .pc_inc    (pc_inc),
    .jump      (jump),
    .z_flag    (z_flag),
    .imem      (imem),
    .pc        (pc),
    .ir        (ir),
    .operand   (operand),
    .ir_load   (ir_load),
    .halt      (halt)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (imem.imem_en)
      imem.imem_rdata <= mem[imem.imem_addr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    imem_read = 0; pc_inc = 0;
    jump = 0; z_flag = 0;
    reset = 1;
    tick();
    reset = 0;
  endtask

  // One read at current pc (optionally incrementing), then let it land.
  task automatic fetch(input logic inc);
    imem_read = 1; pc_inc = inc;
    tick();
    imem_read = 0; pc_inc = 0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1; imem_read = 1;
    pc_inc = 0; jump = 0; z_flag = 0;
    tick();
    #1;
    checks++;
    if (imem.imem_en !== 1'b0) begin
      errors++;
      $display("FAIL rst_en got %b exp 0", imem.imem_en);
    end
    checks++;
    if ({pc, ir, operand, ir_load, halt} !== 42'd0) begin
      errors++;
      $display("FAIL rst_state pc=%h ir=%h op=%h ld=%b h=%b exp all 0",
               pc, ir, operand, ir_load, halt);
    end
    imem_read = 0;
    reset = 0;
    tick();
  endtask

  task automatic test_fetch_ir();
    do_reset();
    mem[0] = 16'h7123;
    imem_read = 1;
    #1;
    checks++;
    if (imem.imem_en !== 1'b1 || imem.imem_addr !== 8'h00) begin
      errors++;
      $display("FAIL rd_issue en=%b addr=%h exp 1/00",
               imem.imem_en, imem.imem_addr);
    end
    tick();
    imem_read = 0;
    checks++;
    if (ir !== 16'h0 || ir_load !== 1'b0) begin
      errors++;
      $display("FAIL ir_early ir=%h ld=%b exp 0000/0", ir, ir_load);
    end
    tick();
    checks++;
    if (ir !== 16'h7123 || ir_load !== 1'b1 || operand !== 16'h0) begin
      errors++;
      $display("FAIL ir_cap ir=%h ld=%b op=%h exp 7123/1/0000",
               ir, ir_load, operand);
    end
    tick();
    checks++;
    if (ir_load !== 1'b0) begin
      errors++;
      $display("FAIL ir_load_pulse got %b exp 0", ir_load);
    end
  endtask

  task automatic test_loadim();
    do_reset();
    mem[0] = 16'h2100;
    mem[1] = 16'h00AB;
    fetch(1);
    fetch(0);
    checks++;
    if (ir !== 16'h2100 || operand !== 16'h00AB || ir_load !== 1'b0) begin
      errors++;
      $display("FAIL loadim ir=%h op=%h ld=%b exp 2100/00AB/0",
               ir, operand, ir_load);
    end
    fetch(0);
    checks++;
    if (ir !== 16'h00AB || operand !== 16'h00AB || ir_load !== 1'b1) begin
      errors++;
      $display("FAIL need_clr ir=%h op=%h ld=%b exp 00AB/00AB/1",
               ir, operand, ir_load);
    end
  endtask

  task automatic test_jumpnz();
    do_reset();
    mem[0] = 16'hB120;
    mem[1] = 16'h0040;
    fetch(1);
    fetch(1);
    jump = 1;
    tick();
    checks++;
    if (pc !== 8'h02) begin
      errors++;
      $display("FAIL jump_only pc=%h exp 02", pc);
    end
    pc_inc = 1; z_flag = 0;
    tick();
    jump = 0; pc_inc = 0;
    checks++;
    if (pc !== 8'h40 || ir !== 16'hB120) begin
      errors++;
      $display("FAIL jnz_taken pc=%h ir=%h exp 40/B120", pc, ir);
    end
    do_reset();
    fetch(1);
    fetch(1);
    jump = 1; pc_inc = 1; z_flag = 1;
    tick();
    jump = 0; pc_inc = 0; z_flag = 0;
    checks++;
    if (pc !== 8'h03) begin
      errors++;
      $display("FAIL jnz_not_taken pc=%h exp 03", pc);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    mem[0] = 16'hB000;
    mem[1] = 16'h00FF;
    mem[255] = 16'h1234;
    fetch(1);
    fetch(1);
    jump = 1; pc_inc = 1;
    tick();
    jump = 0; pc_inc = 0;
    checks++;
    if (pc !== 8'hFF) begin
      errors++;
      $display("FAIL wrap_setup pc=%h exp FF", pc);
    end
    imem_read = 1; pc_inc = 1;
    #1;
    checks++;
    if (imem.imem_addr !== 8'hFF) begin
      errors++;
      $display("FAIL rd_pre_inc addr=%h exp FF", imem.imem_addr);
    end
    tick();
    imem_read = 0; pc_inc = 0;
    checks++;
    if (pc !== 8'h00) begin
      errors++;
      $display("FAIL wrap pc=%h exp 00", pc);
    end
    tick();
    checks++;
    if (ir !== 16'h1234) begin
      errors++;
      $display("FAIL wrap_ir ir=%h exp 1234", ir);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    mem[0] = 16'h2000;
    mem[1] = 16'h0055;
    mem[2] = 16'h4444;
    imem_read = 1; pc_inc = 1;
    tick();
    tick();
    checks++;
    if (ir !== 16'h2000 || ir_load !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ir ir=%h ld=%b exp 2000/1", ir, ir_load);
    end
    tick();
    imem_read = 0; pc_inc = 0;
    checks++;
    if (operand !== 16'h0055 || ir !== 16'h2000) begin
      errors++;
      $display("FAIL b2b_op op=%h ir=%h exp 0055/2000", operand, ir);
    end
    tick();
    checks++;
    if (ir !== 16'h4444 || operand !== 16'h0055 || pc !== 8'h03) begin
      errors++;
      $display("FAIL b2b_ir2 ir=%h op=%h pc=%h exp 4444/0055/03",
               ir, operand, pc);
    end
  endtask

  task automatic test_reset_pend();
    do_reset();
    mem[0] = 16'h2000;
    mem[1] = 16'h0077;
    fetch(1);
    imem_read = 1;
    tick();
    imem_read = 0;
    reset = 1;
    tick();
    reset = 0;
    checks++;
    if (ir !== 16'h0 || operand !== 16'h0 || pc !== 8'h0 || ir_load !== 1'b0) begin
      errors++;
      $display("FAIL rst_pend ir=%h op=%h pc=%h ld=%b exp 0/0/0/0",
               ir, operand, pc, ir_load);
    end
    tick();
    checks++;
    if (operand !== 16'h0) begin
      errors++;
      $display("FAIL rst_pend_drop op=%h exp 0000", operand);
    end
    fetch(0);
    checks++;
    if (ir !== 16'h2000 || operand !== 16'h0) begin
      errors++;
      $display("FAIL rst_pend_dst ir=%h op=%h exp 2000/0000", ir, operand);
    end
  endtask

  task automatic test_halt();
    do_reset();
    mem[0] = 16'hF000;
    mem[1] = 16'h3333;
    fetch(1);
`ifdef INSTR_FETCH_HALT_EN
    checks++;
    if (halt !== 1'b1 || ir !== 16'hF000) begin
      errors++;
      $display("FAIL halt_set h=%b ir=%h exp 1/F000", halt, ir);
    end
    imem_read = 1; pc_inc = 1;
    #1;
    checks++;
    if (imem.imem_en !== 1'b0) begin
      errors++;
      $display("FAIL halt_en got %b exp 0", imem.imem_en);
    end
    tick();
    tick();
    imem_read = 0; pc_inc = 0;
    checks++;
    if (pc !== 8'h01 || ir !== 16'hF000) begin
      errors++;
      $display("FAIL halt_frozen pc=%h ir=%h exp 01/F000", pc, ir);
    end
    do_reset();
    checks++;
    if (halt !== 1'b0) begin
      errors++;
      $display("FAIL halt_clr got %b exp 0", halt);
    end
`else
    checks++;
    if (halt !== 1'b0 || ir !== 16'hF000) begin
      errors++;
      $display("FAIL no_halt h=%b ir=%h exp 0/F000", halt, ir);
    end
    fetch(1);
    checks++;
    if (ir !== 16'h3333 || pc !== 8'h02) begin
      errors++;
      $display("FAIL past_end ir=%h pc=%h exp 3333/02", ir, pc);
    end
`endif
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0;
    imem.imem_rdata = 16'h0;
    reset = 1; imem_read = 0;
    pc_inc = 0; jump = 0; z_flag = 0;
    test_reset();
    test_fetch_ir();
    test_loadim();
    test_jumpnz();
    test_wrap();
    test_back_to_back();
    test_reset_pend();
    test_halt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
